// File: rtl/fl_pkg.sv
// Shared types and helpers for the multi-port free list.
// Pure declarations: no logic, no latency, no flow control.
// Port-array typedefs describe the default 8-entry, 2-alloc, 2-free geometry.
package fl_pkg;

    localparam int FL_MAX_SIZE       = 1024;
    localparam int FL_SIZE           = 8;
    localparam int FL_ALLOC_PORTS    = 2;
    localparam int FL_FREE_PORTS     = 2;

    typedef logic [FL_ALLOC_PORTS-1:0][FL_SIZE-1:0] alloc_oh_t;
    typedef logic [FL_FREE_PORTS-1:0][FL_SIZE-1:0]  free_oh_t;

    function automatic int fl_cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

    // Callers zero-extend narrower maps to FL_MAX_SIZE before calling.
    function automatic int fl_popcount(input logic [FL_MAX_SIZE-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < FL_MAX_SIZE; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fl_prio_pick.sv
// Single-port lowest-set-bit picker; chains by passing the remaining free map on.
// Latency: purely combinational.
// Backpressure: none; an empty input map yields no grant and an empty output map.
module fl_prio_pick #(
    parameter int SIZE = 8
) (
    input  logic            req,
    input  logic [SIZE-1:0] avail_in,
    output logic            gnt,
    output logic [SIZE-1:0] onehot,
    output logic [SIZE-1:0] avail_out
);

    logic [SIZE-1:0] lowest;

    always_comb begin
        lowest    = avail_in & (~avail_in + SIZE'(1));
        gnt       = req & (|avail_in);
        onehot    = gnt ? lowest : '0;
        avail_out = avail_in & ~onehot;
    end

endmodule

// File: rtl/free_list_mp.sv
// Multi-port free list: in-order allocation of lowest free entries, multi-port release.
// Latency: grants combinational from the registered map; frees visible the next cycle.
// Backpressure: empty map denies all grants; optional sticky err with FL_ERR_CHECK_EN.
module free_list_mp
    import fl_pkg::*;
#(
    parameter int              SIZE        = 8,
    parameter int              ALLOC_PORTS = 2,
    parameter int              FREE_PORTS  = 2,
    parameter logic [SIZE-1:0] INIT_FREE   = '1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ALLOC_PORTS-1:0]               alloc_req,
    output logic [ALLOC_PORTS-1:0]               alloc_gnt,
    output logic [ALLOC_PORTS-1:0][SIZE-1:0]     alloc_onehot,
    input  logic [FREE_PORTS-1:0]                free_vld,
    input  logic [FREE_PORTS-1:0][SIZE-1:0]      free_onehot,
    output logic [SIZE-1:0]                      free_bitmap,
    output logic [fl_cnt_w(SIZE)-1:0]            free_count,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 err
);

    localparam int            CW       = fl_cnt_w(SIZE);
    localparam logic [CW-1:0] INIT_CNT = CW'(fl_popcount(FL_MAX_SIZE'(INIT_FREE)));

    logic [SIZE-1:0]              bitmap_q, bitmap_d;
    logic [CW-1:0]                count_q, count_d;
    logic [ALLOC_PORTS:0][SIZE-1:0] avail_chain;
    logic [SIZE-1:0]              taken, freed;
    logic [FL_MAX_SIZE-1:0]       pc_ext;

    // Gating the chain head with rst_n keeps every grant low while in reset.
    assign avail_chain[0] = rst_n ? bitmap_q : '0;

    for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_pick
        fl_prio_pick #(.SIZE(SIZE)) u_pick (
            .req       (alloc_req[k]),
            .avail_in  (avail_chain[k]),
            .gnt       (alloc_gnt[k]),
            .onehot    (alloc_onehot[k]),
            .avail_out (avail_chain[k+1])
        );
    end

    always_comb begin
        taken = bitmap_q & ~avail_chain[ALLOC_PORTS];
        freed = '0;
        for (int p = 0; p < FREE_PORTS; p++) begin
            if (free_vld[p]) begin
                freed = freed | free_onehot[p];
            end
        end
        bitmap_d = (bitmap_q & ~taken) | freed;
        pc_ext   = '0;
        pc_ext[SIZE-1:0] = bitmap_d;
        count_d  = CW'(fl_popcount(pc_ext));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q <= INIT_FREE;
            count_q  <= INIT_CNT;
        end else begin
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
        end
    end

    assign free_bitmap = bitmap_q;
    assign free_count  = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(SIZE));

`ifdef FL_ERR_CHECK_EN
    logic            err_q, err_d;
    logic [SIZE-1:0] seen, dup;
    logic            bad_oh;

    // Granted entries are a subset of bitmap_q, so one overlap test covers both cases.
    always_comb begin
        seen   = '0;
        dup    = '0;
        bad_oh = 1'b0;
        for (int p = 0; p < FREE_PORTS; p++) begin
            if (free_vld[p]) begin
                dup  = dup | (seen & free_onehot[p]);
                seen = seen | free_onehot[p];
                if (!$onehot(free_onehot[p])) begin
                    bad_oh = 1'b1;
                end
            end
        end
        err_d = err_q | bad_oh | (|dup) | (|(freed & bitmap_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mp.sv
// Bench for free_list_mp (8 entries, 2 alloc ports, 2 free ports, INIT_FREE=8'hF0).
module tb_free_list_mp;
    import fl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] alloc_req, alloc_gnt, free_vld;
    alloc_oh_t  alloc_onehot;
    free_oh_t   free_onehot;
    logic [7:0] free_bitmap;
    logic [3:0] free_count;
    logic       empty, full, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_bm;
    logic       model_err;

`ifdef FL_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] gnt;
        logic [7:0] oh0;
        logic [7:0] oh1;
    } alloc_exp_t;

    typedef struct packed {
        logic [7:0] bm;
        logic [3:0] cnt;
        logic       err;
    } state_exp_t;

    alloc_exp_t alloc_q[$];
    state_exp_t state_q[$];

    always #5 clk = ~clk;

    free_list_mp #(
        .SIZE        (8),
        .ALLOC_PORTS (2),
        .FREE_PORTS  (2),
        .INIT_FREE   (8'hF0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_onehot (alloc_onehot),
        .free_vld     (free_vld),
        .free_onehot  (free_onehot),
        .free_bitmap  (free_bitmap),
        .free_count   (free_count),
        .empty        (empty),
        .full         (full),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic alloc_exp_t model_alloc(input logic [1:0] req, input logic [7:0] bm);
        alloc_exp_t e;
        logic [7:0] av;
        logic       blocked, found;
        int         pick;
        e = '0;
        av = bm;
        blocked = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (req[k] && !blocked) begin
                found = 1'b0;
                pick  = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!found && av[i]) begin
                        found = 1'b1;
                        pick  = i;
                    end
                end
                if (found) begin
                    e.gnt[k] = 1'b1;
                    if (k == 0) e.oh0[pick] = 1'b1;
                    else        e.oh1[pick] = 1'b1;
                    av[pick] = 1'b0;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic step(input string tag, input logic [1:0] req, input logic [1:0] fv,
                        input logic [7:0] f0, input logic [7:0] f1);
        alloc_exp_t ea;
        state_exp_t es;
        logic [7:0] taken, freed;
        logic       viol;
        alloc_req      = req;
        free_vld       = fv;
        free_onehot[0] = f0;
        free_onehot[1] = f1;
        ea = model_alloc(req, model_bm);
        alloc_q.push_back(ea);
        taken = ea.oh0 | ea.oh1;
        freed = (fv[0] ? f0 : 8'h00) | (fv[1] ? f1 : 8'h00);
        viol  = (fv[0] && !$onehot(f0)) || (fv[1] && !$onehot(f1)) ||
                (fv == 2'b11 && (f0 & f1) != 8'h00) || ((freed & model_bm) != 8'h00);
        model_bm = (model_bm & ~taken) | freed;
        if (ERR_EN && viol) model_err = 1'b1;
        es.bm  = model_bm;
        es.cnt = 4'($countones(model_bm));
        es.err = model_err;
        state_q.push_back(es);
        #2;
        ea = alloc_q.pop_front();
        chk({tag, ".gnt"}, 32'(alloc_gnt), 32'(ea.gnt));
        chk({tag, ".oh0"}, 32'(alloc_onehot[0]), 32'(ea.oh0));
        chk({tag, ".oh1"}, 32'(alloc_onehot[1]), 32'(ea.oh1));
        @(posedge clk);
        #1;
        es = state_q.pop_front();
        chk({tag, ".bitmap"}, 32'(free_bitmap), 32'(es.bm));
        chk({tag, ".count"},  32'(free_count),  32'(es.cnt));
        chk({tag, ".empty"},  32'(empty),       32'(es.cnt == 4'd0));
        chk({tag, ".full"},   32'(full),        32'(es.cnt == 4'd8));
        chk({tag, ".err"},    32'(err),         32'(es.err));
    endtask

    initial begin
        logic [1:0] rq, fv;
        logic [7:0] f0, f1;
        int         idx[$];
        int         j;

        rst_n = 1'b0;
        alloc_req = 2'b11;
        free_vld = 2'b00;
        free_onehot = '0;
        model_bm = 8'hF0;
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst.gnt",    32'(alloc_gnt),       32'h0);
        chk("rst.oh0",    32'(alloc_onehot[0]), 32'h0);
        chk("rst.bitmap", 32'(free_bitmap),     32'hF0);
        chk("rst.count",  32'(free_count),      32'd4);
        chk("rst.err",    32'(err),             32'h0);

        // Release mid-cycle with the request still held.
        rst_n = 1'b1;
        #1;
        step("init_f0", 2'b11, 2'b00, 8'h00, 8'h00);
        step("drain",   2'b11, 2'b00, 8'h00, 8'h00);
        step("nobyp_a", 2'b01, 2'b01, 8'h04, 8'h00);
        step("nobyp_b", 2'b01, 2'b00, 8'h00, 8'h00);
        step("set80",   2'b00, 2'b01, 8'h80, 8'h00);
        step("last_a",  2'b11, 2'b00, 8'h00, 8'h00);
        step("last_b",  2'b01, 2'b00, 8'h00, 8'h00);
        step("set0c",   2'b00, 2'b11, 8'h04, 8'h08);
        step("skip0",   2'b10, 2'b00, 8'h00, 8'h00);
        step("fill_a",  2'b00, 2'b11, 8'h01, 8'h02);
        step("fill_b",  2'b00, 2'b11, 8'h10, 8'h20);
        step("fill_c",  2'b00, 2'b11, 8'h40, 8'h80);
        step("fill_d",  2'b00, 2'b01, 8'h04, 8'h00);

        for (int c = 0; c < 10000; c++) begin
            rq = 2'($urandom_range(0, 3));
            fv = 2'b00;
            f0 = 8'h00;
            f1 = 8'h00;
            idx = {};
            for (int i = 0; i < 8; i++) if (!model_bm[i]) idx.push_back(i);
            if (idx.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, idx.size() - 1));
                f0[idx[j]] = 1'b1;
                fv[0] = 1'b1;
                idx.delete(j);
            end
            if (idx.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, idx.size() - 1));
                f1[idx[j]] = 1'b1;
                fv[1] = 1'b1;
            end
            step("soak", rq, fv, f0, f1);
        end

        for (int i = 0; i < 8; i++) begin
            if (!model_bm[i]) begin
                f0 = 8'h00;
                f0[i] = 1'b1;
                step("refill", 2'b00, 2'b01, f0, 8'h00);
            end
        end

        step("dblfree", 2'b00, 2'b01, 8'h01, 8'h00);
        step("sticky1", 2'b00, 2'b00, 8'h00, 8'h00);
        step("sticky2", 2'b01, 2'b00, 8'h00, 8'h00);

        alloc_req = 2'b11;
        free_vld  = 2'b00;
        rst_n = 1'b0;
        #3;
        chk("rst2.err",    32'(err),         32'h0);
        chk("rst2.bitmap", 32'(free_bitmap), 32'hF0);
        chk("rst2.count",  32'(free_count),  32'd4);
        chk("rst2.gnt",    32'(alloc_gnt),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list_mp.md
FREE_LIST_MP -- requirements
Module: free_list_mp

Interface
REQ-001 SHALL have parameter SIZE, default 8: number of tracked entries (>=2).
REQ-002 SHALL have parameter ALLOC_PORTS, default 2: allocation ports per cycle (1..SIZE).
REQ-003 SHALL have parameter FREE_PORTS, default 2: release ports per cycle (>=1).
REQ-004 SHALL have parameter INIT_FREE, default all-ones [SIZE]: bitmap loaded at reset (1 = free).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port alloc_req, input, [ALLOC_PORTS]: per-port allocation request.
REQ-008 SHALL have port alloc_gnt, output, [ALLOC_PORTS]: per-port grant, combinational, same cycle as request.
REQ-009 SHALL have port alloc_onehot, output, [ALLOC_PORTS][SIZE]: granted entry, one-hot; all-zero when not granted.
REQ-010 SHALL have port free_vld, input, [FREE_PORTS]: per-port release valid.
REQ-011 SHALL have port free_onehot, input, [FREE_PORTS][SIZE]: entry to release, one-hot.
REQ-012 SHALL have port free_bitmap, output, [SIZE]: registered free map.
REQ-013 SHALL have port free_count, output, [$clog2(SIZE+1)]: number of set bits in free_bitmap.
REQ-014 SHALL have ports empty and full, output, 1 each: free_count==0 and free_count==SIZE.
REQ-015 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-016 Port 0 SHALL receive the lowest-index free entry, port k the (k+1)-th lowest free entry, excluding entries taken by lower ports.
REQ-017 Grants SHALL be in order: port k granted only if alloc_req[k]=1, every lower requesting port is granted, and enough free entries remain.
REQ-018 Non-requesting ports SHALL be skipped and SHALL consume no entry.
REQ-019 Allocation SHALL see only the registered bitmap; entries freed in cycle N become allocatable in cycle N+1, with no bypass.
REQ-020 Next bitmap = (free_bitmap & ~OR(granted onehots)) | OR(valid free onehots).
REQ-021 free_count SHALL be registered alongside the bitmap with no extra latency; empty and full SHALL derive from it.
REQ-022 When empty=1, all alloc_gnt SHALL be 0 regardless of alloc_req.
REQ-023 Freeing an entry that is already free, or that is granted in the same cycle, is illegal: bitmap result is the OR per REQ-020 and err handling follows REQ-027.
REQ-024 Two free ports naming the same entry in one cycle is illegal; the entry SHALL end up free.

Reset
REQ-025 While rst_n=0, SHALL hold free_bitmap=INIT_FREE, free_count=popcount(INIT_FREE), err=0, and all alloc_gnt=0.
REQ-026 Deassertion mid-request SHALL grant from INIT_FREE on the first clocked cycle; no partial state is retained.

Configuration
REQ-027 With FL_ERR_CHECK_EN defined: err SHALL set on the clock edge after any REQ-023/REQ-024 violation or a non-one-hot free_onehot with free_vld=1, and hold until reset. Without it, err SHALL be tied 0 and the check logic SHALL be absent.

Structure
REQ-028 A shared package fl_pkg SHALL hold the count-width function, popcount function, and the ALLOC/FREE port-array typedefs.
REQ-029 A sub-module fl_prio_pick SHALL implement the single-port lowest-set-bit pick with masked-input/masked-output chaining; free_list_mp SHALL instantiate it ALLOC_PORTS times in cascade.

Verification (SIZE=8, ALLOC_PORTS=2, FREE_PORTS=2)
REQ-030 Reset with INIT_FREE=8'hF0, req=2'b11: gnt=2'b11, onehot0=8'h10, onehot1=8'h20; next bitmap=8'hC0, count=2.
REQ-031 Bitmap=8'h80, req=2'b11: gnt=2'b01, onehot0=8'h80; next empty=1; following cycle req=2'b01 gives gnt=0.
REQ-032 Bitmap=8'h00, free 8'h04 and req=2'b01 in the same cycle: gnt=0 that cycle; next cycle gnt=2'b01, onehot0=8'h04.
REQ-033 Bitmap=8'h0C, req=2'b10: gnt=2'b10, onehot1=8'h04, onehot0=0; next bitmap=8'h08.
REQ-034 With FL_ERR_CHECK_EN, bitmap=8'hFF, free 8'h01: err=1 next cycle and stays 1 until rst_n=0; without the macro, err=0.
REQ-035 Random alloc/free soak, 10k cycles: no entry granted twice without an intervening free; free_count always equals popcount(free_bitmap).
